// File: rtl/arm_pkg.sv
// Shared definitions for the memory-stage SRAM sequencer: state encoding,
// external SRAM geometry and the data-segment base address.
package arm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_t;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    localparam logic [31:0] DATA_BASE_ADDR = 32'd1024;

    // Half-word SRAM address for one phase of a 32-bit word access.
    function automatic logic [SRAM_ADDR_W-1:0] half_addr(
        input logic [SRAM_ADDR_W-2:0] word_idx,
        input logic                   hi_half
    );
        return {word_idx, hi_half};
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Load/decrement down-counter with a zero flag; load takes priority and the
// count saturates at zero.
module wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// Sequences one 32-bit load/store as two 16-bit SRAM phases (low half, then
// high half), each held WAIT_CYCLES cycles, and stalls the pipeline meanwhile.
module sram_controller
    import arm_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DATA_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    // Handshake: ready is combinational. In IDLE it drops in the same cycle a
    // request appears; it stays low through LO and HI, and rises for exactly
    // the one DONE cycle, at whose closing edge the pipeline advances.

    sram_state_t state;
    sram_state_t state_next;

    logic                   request;
    logic                   accept;
    logic                   lo_end;
    logic                   hi_end;
    logic                   in_phase;
    logic                   cnt_load;
    logic                   cnt_dec;
    logic                   cnt_zero;
    logic [CNT_W-1:0]       cnt_value;

    logic                   op_write;
    logic [SRAM_ADDR_W-2:0] word_idx;
    logic [15:0]            wdata_hi;
    logic [15:0]            lo_buf;
    logic [31:0]            offset;
    logic                   unused_offset_bits;

    assign request = mem_read | mem_write;
    assign offset  = address - BASE_ADDR;
    // Offset bits above 18 alias onto the 256K half-word SRAM; [1:0] is the
    // byte lane of a word-aligned access.
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_value(CNT_LOAD),
        .dec       (cnt_dec),
        .count     (cnt_value),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (request)  state_next = ST_LO;
            ST_LO:   if (cnt_zero) state_next = ST_HI;
            ST_HI:   if (cnt_zero) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_phase   = (state == ST_LO) || (state == ST_HI);
        accept     = (state == ST_IDLE) && request;
        lo_end     = (state == ST_LO) && cnt_zero;
        hi_end     = (state == ST_HI) && cnt_zero;
        ready      = ((state == ST_IDLE) && !request) || (state == ST_DONE);
        sram_we_n  = !(in_phase && op_write);
        sram_dq_oe = in_phase && op_write;
        cnt_load   = accept || lo_end;
        cnt_dec    = in_phase;
    end

    // Pad address/data are registered and only move on phase entry. The low
    // read half is parked in lo_buf so read_data updates as a whole word.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_write    <= 1'b0;
            word_idx    <= '0;
            wdata_hi    <= '0;
            lo_buf      <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            read_data   <= '0;
        end else begin
            if (accept) begin
                op_write    <= mem_write;
                word_idx    <= offset[18:2];
                wdata_hi    <= write_data[31:16];
                sram_addr   <= half_addr(offset[18:2], 1'b0);
                sram_dq_out <= write_data[15:0];
            end
            if (lo_end) begin
                sram_addr   <= half_addr(word_idx, 1'b1);
                sram_dq_out <= wdata_hi;
                if (!op_write) begin
                    lo_buf <= sram_dq_in;
                end
            end
            if (hi_end && !op_write) begin
                read_data <= {sram_dq_in, lo_buf};
            end
        end
    end

endmodule
